// File: rtl/aes128_key_expand_if.sv
// Key-schedule port bundle: key load/advance from the cipher core, round-key words back.
// Optional done flag exists only when AES_KEY_EXPAND_DONE_EN is defined.
interface aes128_key_expand_if;
   logic         kld;
   logic [127:0] key;
   logic         enable;
   logic [31:0]  rkey0;
   logic [31:0]  rkey1;
   logic [31:0]  rkey2;
   logic [31:0]  rkey3;
`ifdef AES_KEY_EXPAND_DONE_EN
   logic         done;

   modport master (output kld, key, enable,
                   input  rkey0, rkey1, rkey2, rkey3, done);
   modport slave  (input  kld, key, enable,
                   output rkey0, rkey1, rkey2, rkey3, done);
`else
   modport master (output kld, key, enable,
                   input  rkey0, rkey1, rkey2, rkey3);
   modport slave  (input  kld, key, enable,
                   output rkey0, rkey1, rkey2, rkey3);
`endif
endinterface

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: one round key per enabled edge, K0 one edge after kld, saturates at K10.
// No backpressure; outputs are registered. Macro AES_KEY_EXPAND_DONE_EN adds a done flag (rnd==10).

module aes_sbox_lut (
   input  logic [7:0] a,
   output logic [7:0] d
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign d = SBOX[a];
endmodule

module aes128_key_expand (
   input  logic clk,
   input  logic rst,
   aes128_key_expand_if.slave bus
);
   localparam logic [3:0] LAST_RND = 4'd10;

   logic [3:0][31:0] w_q, w_d;
   logic [3:0]       rnd_q, rnd_d;
   logic [7:0]       rcon_q, rcon_d;

   logic [31:0] rot_w;
   logic [31:0] sub_w;
   logic [31:0] t_w;
   logic [31:0] nxt0, nxt1, nxt2, nxt3;

   assign rot_w = {w_q[3][23:0], w_q[3][31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox_lut u_sbox (
         .a (rot_w[8*i +: 8]),
         .d (sub_w[8*i +: 8])
      );
   end

   // rcon_q always holds Rcon(rnd_q+1), the constant for the step about to be taken
   assign t_w  = sub_w ^ {rcon_q, 24'h000000};
   assign nxt0 = w_q[0] ^ t_w;
   assign nxt1 = w_q[1] ^ nxt0;
   assign nxt2 = w_q[2] ^ nxt1;
   assign nxt3 = w_q[3] ^ nxt2;

   always_comb begin
      w_d    = w_q;
      rnd_d  = rnd_q;
      rcon_d = rcon_q;
      if (bus.kld) begin
         w_d[0] = bus.key[127:96];
         w_d[1] = bus.key[95:64];
         w_d[2] = bus.key[63:32];
         w_d[3] = bus.key[31:0];
         rnd_d  = 4'd0;
         rcon_d = 8'h01;
      end else if (bus.enable && (rnd_q < LAST_RND)) begin
         w_d[0] = nxt0;
         w_d[1] = nxt1;
         w_d[2] = nxt2;
         w_d[3] = nxt3;
         rnd_d  = rnd_q + 4'd1;
         rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q    <= '0;
         rnd_q  <= 4'd0;
         rcon_q <= 8'h01;
      end else begin
         w_q    <= w_d;
         rnd_q  <= rnd_d;
         rcon_q <= rcon_d;
      end
   end

   assign bus.rkey0 = w_q[0];
   assign bus.rkey1 = w_q[1];
   assign bus.rkey2 = w_q[2];
   assign bus.rkey3 = w_q[3];

`ifdef AES_KEY_EXPAND_DONE_EN
   assign bus.done = (rnd_q == LAST_RND);
`endif
endmodule

// File: tb/tb_aes128_key_expand.sv
// Bench for aes128_key_expand: directed FIPS-197 vectors plus random load/advance/reset traffic
// checked against a textbook key-expansion model built from GF(2^8) arithmetic.
module tb_aes128_key_expand;
   logic clk = 1'b0;
   logic rst;

   aes128_key_expand_if bus ();

   aes128_key_expand dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_K1   = {4{32'h62636363}};

   int checks = 0;
   int errors = 0;

   logic [7:0]   sb [256];
   logic [127:0] m_key;
   int           m_rnd;

   wire [127:0] rk_all = {bus.rkey0, bus.rkey1, bus.rkey2, bus.rkey3};

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse then the affine map
   task automatic build_sbox();
      for (int b = 0; b < 256; b++) begin
         logic [7:0] inv = 8'h00;
         for (int x = 1; x < 256; x++)
            if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
         sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] rnd_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk(tag, rk_all, round_key(m_key, m_rnd));
`ifdef AES_KEY_EXPAND_DONE_EN
      chk({tag, "_done"}, {127'b0, bus.done}, {127'b0, (m_rnd == 10)});
`endif
   endtask

   // Called at a falling edge; applies inputs for one rising edge and returns at the next falling edge
   task automatic cyc(input logic k, input logic [127:0] kv, input logic e);
      bus.kld    = k;
      bus.key    = kv;
      bus.enable = e;
      @(posedge clk);
      if (k) begin
         m_key = kv;
         m_rnd = 0;
      end else if (e && m_rnd < 10) begin
         m_rnd++;
      end
      @(negedge clk);
   endtask

   task automatic async_rst();
      #2 rst = 1'b1;
      #1 chk("async_rst_now", rk_all, 128'h0);
      m_key = 128'h0;
      m_rnd = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      bus.kld    = 1'b0;
      bus.enable = 1'b0;
      bus.key    = 128'h0;
      m_key      = 128'h0;
      m_rnd      = 0;
      build_sbox();

      #1 chk("reset_initial", rk_all, 128'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.kld    = ~bus.kld;
         bus.enable = 1'b1;
         bus.key    = rnd_key();
         @(posedge clk);
         #1 chk("reset_hold", rk_all, 128'h0);
      end
`ifdef AES_KEY_EXPAND_DONE_EN
      chk("reset_done", {127'b0, bus.done}, 128'h0);
`endif
      @(negedge clk);
      rst = 1'b0;

      cyc(1'b1, 128'h0, 1'b0);
      chk("zero_k0", rk_all, 128'h0);
      cyc(1'b0, rnd_key(), 1'b1);
      chk("zero_k1", rk_all, ZERO_K1);
      chk_model("zero_k1_model");

      cyc(1'b1, FIPS_KEY, 1'b0);
      chk("fips_k0", rk_all, FIPS_KEY);
      cyc(1'b0, rnd_key(), 1'b1);
      chk("fips_k1", rk_all, FIPS_K1);
      for (int r = 2; r <= 10; r++) begin
         cyc(1'b0, rnd_key(), 1'b1);
         chk_model($sformatf("fips_k%0d", r));
      end
      chk("fips_k10", rk_all, FIPS_K10);
`ifdef AES_KEY_EXPAND_DONE_EN
      chk("done_k10", {127'b0, bus.done}, 128'h1);
`endif
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, rnd_key(), 1'b1);
         chk("saturate", rk_all, FIPS_K10);
      end

      cyc(1'b1, FIPS_KEY, 1'b0);
      repeat (3) cyc(1'b0, rnd_key(), 1'b1);
      repeat (2) begin
         cyc(1'b0, rnd_key(), 1'b0);
         chk_model("hold_r3");
      end
      repeat (2) cyc(1'b0, rnd_key(), 1'b1);
      chk_model("round5");
      cyc(1'b1, 128'h0, 1'b1);
      chk("restart_prio", rk_all, 128'h0);
`ifdef AES_KEY_EXPAND_DONE_EN
      chk("restart_done", {127'b0, bus.done}, 128'h0);
`endif
      cyc(1'b0, rnd_key(), 1'b1);
      chk("restart_k1", rk_all, ZERO_K1);

      cyc(1'b1, FIPS_KEY, 1'b0);
      repeat (3) cyc(1'b0, rnd_key(), 1'b1);
      async_rst();
      cyc(1'b1, FIPS_KEY, 1'b0);
      cyc(1'b0, rnd_key(), 1'b1);
      chk("post_rst_k1", rk_all, FIPS_K1);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            async_rst();
         end else begin
            cyc($urandom_range(0, 15) == 0, rnd_key(), $urandom_range(0, 3) != 0);
         end
         chk_model("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/aes128_key_expand.md
Name: aes128_key_expand

Overview:
- Iterative AES-128 key schedule. Produces one 128-bit round key per enabled clock as four 32-bit words.
- Sits beside the AES round datapath. The core pulses kld with the cipher key, then holds enable high for one cycle per round.
- Contains four instances of a combinational 256-entry S-box LUT submodule (aes_sbox_lut, 8-bit a -> 8-bit d) for SubWord.

Parameters:
- none (AES-128 only; Nk=4, 10 rounds fixed)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- kld  input  1  load cipher key (synchronous)
- key  input  128  cipher key; first key byte in the most-significant 8 bits
- enable  input  1  advance to next round key
- rkey0  output  32  round-key word 0 (first byte in [31:24])
- rkey1  output  32  round-key word 1
- rkey2  output  32  round-key word 2
- rkey3  output  32  round-key word 3

Behaviour:
- State: four 32-bit word registers w0..w3, a 4-bit round counter rnd (0..10), and the Rcon byte (derived from rnd or held in a register).
- rkeyN is driven directly from wN. Outputs are registered, with no combinational path from inputs.
- Reset (async, rst=1): w0..w3 = 0, so all rkey outputs = 0x00000000; rnd = 0; Rcon = 0x01. Takes effect immediately, including mid-expansion.
- kld=1 at a rising edge: w0..w3 <= key[127:96], key[95:64], key[63:32], key[31:0]; rnd <= 0. The outputs show K0 (the cipher key) from the next cycle. kld has priority over enable.
- enable=1, kld=0, rnd<10 at a rising edge: compute the next round key, rnd <= rnd+1.
  - t = SubWord(RotWord(w3)) ^ {Rcon(rnd+1), 24'h0}.
  - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}; SubWord applies the S-box to each byte.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36.
- enable=1, rnd==10: saturate; hold the K10 words unchanged.
- enable=0, kld=0: hold all state.
- Latency: kld at edge N gives K0 after edge N. Each enabled edge adds one round, so Ki is visible after i enabled edges.
- kld during an ongoing expansion restarts cleanly from the new key.
- S-box LUT: purely combinational; the standard FIPS-197 forward S-box (e.g. 00->63, 01->7c, 53->ed, ff->16).

Optional Feature:
- Macro AES_KEY_EXPAND_DONE_EN.
- Defined: adds output port done (1 bit), high exactly while rnd==10 (K10 on the outputs). Reset value 0; cleared by kld.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst with key/kld toggling -> rkey0..3 = 00000000 immediately; apply kld with key = 0 -> still 0.
- Zero key: kld with key = 0, then one enable -> rkey0..3 = 62636363 ×4.
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
  - after kld -> K0 equals the key.
  - after 1 enable -> a0fafe17 88542cb1 23a33939 2a6c7605.
  - after 10 enables -> d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- Saturation/hold: after K10, pulse enable 3 more times -> outputs remain K10 (done=1 if enabled). Drop enable mid-schedule -> outputs hold.
- Priority/restart: at round 5, assert kld and enable together with key = 0 -> outputs = 0 (K0). Next enable -> 62636363 ×4.
- Async reset mid-run: rst asserted between edges at round 3 -> outputs become 0 before the next edge. After release, kld + FIPS key gives a correct K1.
